// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result handshake bundle for pipelined_ripple_adder.
// The master side produces operands and consumes results; the slave side is the adder.
interface pipelined_ripple_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_ci;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_co;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_ci, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_co, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_ci, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_co, out_ovf
  );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit add/subtract split into STAGES registered ripple-carry slices of WIDTH/STAGES bits,
// with valid/ready flow control on both sides and a combinational ready path.
module pipelined_ripple_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_ripple_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  logic [STAGES-1:0] v_all;
  logic [STAGES-1:0] en;

  // A stage may load when it, or any stage downstream of it, has a free slot.
  always_comb begin
    en = '0;
    for (int k = 0; k < STAGES; k++) begin
      en[k] = bus.out_ready;
      for (int j = 0; j < STAGES; j++) begin
        if (j >= k && !v_all[j]) begin
          en[k] = 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : gen_stage
      localparam int IN_W   = WIDTH - gi * CHUNK;
      localparam int DONE_W = (gi + 1) * CHUNK;

      logic [IN_W-1:0]   a_in;
      logic [IN_W-1:0]   b_in;
      logic              c_in;
      logic              v_in;
      logic [CHUNK:0]    chunk;
      logic [DONE_W-1:0] s_next;
      logic [DONE_W-1:0] s_reg;
      logic              c_reg;
      logic              v_reg;

      // Stage 0 takes the beat directly; subtract becomes A + ~B + ~ci here.
      if (gi == 0) begin : g_src
        assign a_in = bus.in_a;
        assign b_in = bus.in_b ^ {WIDTH{bus.in_sub}};
        assign c_in = bus.in_ci ^ bus.in_sub;
        assign v_in = bus.in_valid;
      end else begin : g_src
        assign a_in = gen_stage[gi-1].g_pend.a_reg;
        assign b_in = gen_stage[gi-1].g_pend.b_reg;
        assign c_in = gen_stage[gi-1].c_reg;
        assign v_in = gen_stage[gi-1].v_reg;
      end

      assign chunk = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

      if (gi == 0) begin : g_sum
        assign s_next = chunk[CHUNK-1:0];
      end else begin : g_sum
        assign s_next = {chunk[CHUNK-1:0], gen_stage[gi-1].s_reg};
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          v_reg <= 1'b0;
        end else if (en[gi]) begin
          v_reg <= v_in;
        end
      end

      always_ff @(posedge clk) begin
        if (en[gi]) begin
          s_reg <= s_next;
          c_reg <= chunk[CHUNK];
        end
      end

      assign v_all[gi] = v_reg;

      // Only the bits not yet summed travel on to the next slice.
      if (gi < STAGES - 1) begin : g_pend
        logic [IN_W-CHUNK-1:0] a_reg;
        logic [IN_W-CHUNK-1:0] b_reg;

        always_ff @(posedge clk) begin
          if (en[gi]) begin
            a_reg <= a_in[IN_W-1:CHUNK];
            b_reg <= b_in[IN_W-1:CHUNK];
          end
        end
      end else begin : g_last
        logic ovf_reg;

        // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
        always_ff @(posedge clk) begin
          if (en[gi]) begin
            ovf_reg <= chunk[CHUNK-1] ^ a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ chunk[CHUNK];
          end
        end
      end
    end
  endgenerate

  assign bus.in_ready  = en[0];
  assign bus.out_valid = v_all[STAGES-1];
  assign bus.out_sum   = gen_stage[STAGES-1].s_reg;
  assign bus.out_co    = gen_stage[STAGES-1].c_reg;
  assign bus.out_ovf   = gen_stage[STAGES-1].g_last.ovf_reg;
endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

Parametrised, pipelined successor to the 4-bit ripple-carry adder. It splits a WIDTH-bit add/subtract into STAGES registered ripple-carry slices, so the carry chain per cycle is only WIDTH/STAGES full-adder cells deep. Operands enter and results leave through valid/ready handshakes with full backpressure. It sits between operand-producing logic and any consumer of sums that needs a clocked, throughput-1 adder at wider widths.

## Interface
- WIDTH, 16, operand/result width; must be ≥2 and divisible by STAGES
- STAGES, 4, number of pipeline slices (≥1); slice width CHUNK = WIDTH/STAGES
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts the beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_ci  in  1  carry-in (add) / borrow-in (sub)
- in_sub  in  1  0: A+B+ci; 1: A−B−ci
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- out_sum  out  WIDTH  result, modulo 2^WIDTH
- out_co  out  1  carry-out (sub: 1 = no borrow)
- out_ovf  out  1  two's-complement signed overflow

## Operation
- Subtract is implemented as A + ~B + ~ci: B is inverted and the effective carry-in is in_ci XOR in_sub. out_co is the raw adder carry-out in both modes.
- Stage k (0..STAGES−1) ripples bits [k·CHUNK +: CHUNK] using the carry registered by stage k−1. Stage 0 uses the effective carry-in.
- Each stage register holds:
  - the sum bits completed so far;
  - the pending (not yet summed) A and post-inversion B bits;
  - its carry-out;
  - a valid bit v[k].
- out_ovf = carry into the MSB XOR carry out of the MSB, both computed in the last stage.
- Handshake: stage enable en[k] = !v[k] || en[k+1], with en[STAGES] = out_ready. in_ready = en[0]. out_valid = v[STAGES−1]. The ready path is combinational from out_ready to in_ready.
- A beat is accepted when in_valid && in_ready, and a result is consumed when out_valid && out_ready.
- When en[k] is high, stage k loads the stage k−1 contents (stage 0 loads the input beat), and v[k] loads v[k−1] (stage 0 loads in_valid).
- When en[k] is low, stage k holds its contents and v[k] unchanged. Held output data stays stable while out_valid && !out_ready.
- Simultaneous accept and consume on a full pipeline is allowed: everything advances and no bubble is inserted.
- Beats are never dropped, duplicated or reordered.
- Data registers need no reset; only the v[] bits are reset.

## Timing
- Reset: on any rising clk edge with rst=1, all v[] clear. In the following cycle out_valid=0 and in_ready=1. out_sum, out_co and out_ovf are don't-care while out_valid=0, and the bench must not check them.
- Reset mid-operation discards all in-flight beats. A beat presented in the same cycle as rst is discarded.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES−1 if there are no stalls, i.e. STAGES register stages.
- Throughput is 1 beat/cycle while out_ready=1.
- Capacity is STAGES beats. With out_ready held low, in_ready drops after STAGES beats are accepted.
- STAGES=1 gives a single full-width ripple stage followed by one register.

## Test plan
- Carry through all slices: WIDTH=16, STAGES=4, out_ready=1, A=0xFFFF, B=0x0001, ci=0, add → sum 0x0000, co=1, ovf=0, exactly 4 edges after accept.
- Signed overflow and subtract, as back-to-back beats:
  - 0x7FFF+0x0001 → 0x8000, co=0, ovf=1;
  - sub 0x0005−0x0007, ci=0 → 0xFFFE, co=0, ovf=0;
  - sub 0x8000−0x0001, ci=1 → 0x7FFE, co=1, ovf=1.
- Backpressure: stream 10 incrementing beats with in_valid=1 and out_ready=0 for 8 cycles → exactly 4 accepted, in_ready=0 afterwards, out_sum held stable. Release out_ready → all 10 results emerge in order with no gaps.
- Random ready/valid: 10k random operands, modes and carries, with random in_valid and out_ready → results match a reference model in order, with no loss or duplication.
- Reset mid-stream: 3 beats in flight, assert rst for 1 cycle → out_valid=0 and in_ready=1 next cycle, none of the 3 beats ever emerge, and the next beat has 4-cycle latency.
- Parameter sweep: (WIDTH, STAGES) = (4,1), (8,2), (32,8), each with an exhaustive or random self-check and latency equal to STAGES.
